pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three events: load-use hazards, taken branches resolved in EX, and variable-latency data-memory accesses in MEM.
- Also performs the post-reset pipeline flush and keeps saturating stall/flush performance counters.

Parameters:
- INIT_FLUSH_CYCLES, 3: cycles of forced flush after reset release (≥1).
- MEM_TIMEOUT, 64: max MEM_WAIT cycles before mem_timeout is raised (≥1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- id_rn, id_rm  in  5  source registers of the instruction in ID.
- id_uses_rn, id_uses_rm  in  1  ID instruction actually reads Rn / Rm.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_reg_wr  in  1  EX instruction writes the register file.
- ex_mem_to_reg  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_access  in  1  MEM-stage instruction performs a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  load-bubble controls; flush overrides enable at the register.
- mem_timeout  out  1  sticky error flag.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- State register: ST_INIT, ST_RUN, ST_MEM_WAIT; async clear on rst=0.
- While rst=0 and on reset release:
  - state=ST_INIT, init counter=0.
  - All *_en=0, all *_flush=1.
  - mem_timeout=0, stall_cnt=0, flush_cnt=0.
- ST_INIT:
  - All flushes=1, all enables=0.
  - Init counter increments each cycle; move to ST_RUN when it reaches INIT_FLUSH_CYCLES-1, so exactly INIT_FLUSH_CYCLES flush cycles occur.
  - Counters do not count in this state.
- ST_RUN: stall and flush outputs are combinational from the inputs, evaluated in priority order.
  1. Memory stall: mem_access=1 and dmem_ready=0.
     - All enables=0, all flushes=0; the pipeline is frozen.
     - Next state is ST_MEM_WAIT with timeout counter=1.
     - Branch and load-use conditions are ignored this cycle; they are re-evaluated on resume because the stages hold their contents.
  2. Taken branch: ex_branch_taken=1.
     - All enables=1 (PC loads the target).
     - ifid_flush=1 and idex_flush=1, squashing the two younger instructions.
     - Any load-use condition is ignored, since the consumer is squashed.
     - flush_cnt +1.
  3. Load-use hazard: ex_mem_to_reg and ex_reg_wr and ex_rd≠31, and either (id_uses_rn and id_rn==ex_rd) or (id_uses_rm and id_rm==ex_rd).
     - pc_en=0, ifid_en=0.
     - idex_flush=1 (inserts a bubble); exmem_en=1, memwb_en=1.
     - stall_cnt +1.
     - Exactly one bubble; the next cycle re-evaluates normally.
  4. Otherwise: all enables=1, all flushes=0.
- Register 31 (XZR) never creates a hazard.
- ST_MEM_WAIT:
  - Pipeline frozen (all enables=0, flushes=0); stall_cnt +1 per cycle.
  - When dmem_ready=1: this cycle outputs exactly as ST_RUN would (priority rules 2–4 apply), and next state is ST_RUN.
  - The timeout counter increments each waiting cycle. When it reaches MEM_TIMEOUT with dmem_ready still 0, mem_timeout is set (sticky until reset), and the block stays in ST_MEM_WAIT.
  - mem_access dropping while waiting is ignored; only dmem_ready releases the wait.
- The ST_RUN memory-stall cycle itself also counts in stall_cnt.
- Counters saturate at all-ones with no wrap.
- Reset asserted mid-operation returns the block immediately to reset outputs and, after release, to ST_INIT.
- The only registered outputs are mem_timeout, stall_cnt and flush_cnt; all enables and flushes are combinational from state and inputs.

Decomposition:
- Shared pipeline package holds:
  - state enum hz_state_t {ST_INIT, ST_RUN, ST_MEM_WAIT};
  - constant XZR_IDX=5'd31;
  - a packed struct pipe_ctl_t bundling the five enables and four flushes.
- One sub-module: hazard_detect, a pure-combinational load-use comparator (id_rn, id_rm, use bits, ex_rd, ex_reg_wr, ex_mem_to_reg → load_use). It is reused by the forwarding unit.

Test Plan:
- Reset, then release with INIT_FLUSH_CYCLES=3 → all flushes=1 for exactly 3 cycles, then all enables=1 and flushes=0; counters read 0.
- EX load X5 (ex_rd=5, ex_mem_to_reg=1, ex_reg_wr=1); ID reads id_rm=5 with id_uses_rm=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. The same case with ex_rd=31 → no stall.
- ex_branch_taken=1 together with an active load-use condition → ifid_flush=1, idex_flush=1, pc_en=1 (no stall); flush_cnt=1, stall_cnt unchanged.
- mem_access=1 with dmem_ready held 0 for 4 cycles, then 1 → enables=0 for 4 cycles; release cycle has enables=1; stall_cnt=4; with ex_branch_taken=1 held throughout, the flush fires only on the release cycle.
- MEM_TIMEOUT=8 and dmem_ready never asserted → mem_timeout rises after 8 wait cycles and stays 1; pulse rst=0 → mem_timeout=0, state ST_INIT.
- CNT_W=4 and 20 load-use stalls → stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline-control types: sequencer states, the zero-register index
// and the bundle of pipeline-register enables and flushes.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_t;

  // X31 reads as zero and is never written, so it cannot carry a dependency
  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } pipe_ctl_t;

  // Same enable value on all five registers, same flush value on all four
  function automatic pipe_ctl_t ctl_uniform(input logic en, input logic fl);
    pipe_ctl_t c;
    c.pc_en       = en;
    c.ifid_en     = en;
    c.idex_en     = en;
    c.exmem_en    = en;
    c.memwb_en    = en;
    c.ifid_flush  = fl;
    c.idex_flush  = fl;
    c.exmem_flush = fl;
    c.memwb_flush = fl;
    return c;
  endfunction

  // Load-use bubble: hold PC and IF/ID, kill the ID/EX slot, let older stages drain
  function automatic pipe_ctl_t ctl_load_use();
    pipe_ctl_t c;
    c            = ctl_uniform(1'b1, 1'b0);
    c.pc_en      = 1'b0;
    c.ifid_en    = 1'b0;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  // Taken branch: PC takes the target, the two younger instructions are squashed
  function automatic pipe_ctl_t ctl_branch();
    pipe_ctl_t c;
    c            = ctl_uniform(1'b1, 1'b0);
    c.ifid_flush = 1'b1;
    c.idex_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Connection bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  // hazard sources from the datapath
  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic [4:0]       ex_rd;
  logic             ex_reg_wr;
  logic             ex_mem_to_reg;
  logic             ex_branch_taken;
  logic             mem_access;
  logic             dmem_ready;

  // pipeline register controls back to the datapath
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;

  // status
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_reg_wr,
           ex_mem_to_reg, ex_branch_taken, mem_access, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rn, id_rm, id_uses_rn, id_uses_rm, ex_rd, ex_reg_wr,
           ex_mem_to_reg, ex_branch_taken, mem_access, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Pure-combinational load-use comparator: flags when the instruction in ID
// reads a register that the load currently in EX has not yet produced.
// Kept standalone so the forwarding unit can share the same comparison.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rn,
  input  logic [4:0] i_id_rm,
  input  logic       i_id_uses_rn,
  input  logic       i_id_uses_rm,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_reg_wr,
  input  logic       i_ex_mem_to_reg,
  output logic       o_load_use
);

  logic [1:0][4:0] w_src;
  logic [1:0]      w_uses;
  logic [1:0]      w_hit;
  logic            w_load_producer;

  assign w_src  = {i_id_rm, i_id_rn};
  assign w_uses = {i_id_uses_rm, i_id_uses_rn};

  // only a real load writing a real register can stall the consumer
  assign w_load_producer = i_ex_mem_to_reg & i_ex_reg_wr & (i_ex_rd != XZR_IDX);

  // one comparator per source operand; unused operands never match
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign w_hit[gi] = w_uses[gi] & (w_src[gi] == i_ex_rd);
    end
  endgenerate

  assign o_load_use = w_load_producer & (|w_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Sequences the post-reset
// flush, freezes the pipe on slow data-memory accesses, squashes on taken
// branches and inserts a single bubble on load-use hazards. Enables and
// flushes are combinational; only the error flag and counters are registered.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int INIT_FLUSH_CYCLES = 3,
  parameter int MEM_TIMEOUT       = 64,
  parameter int CNT_W             = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_hazard_ctrl_if.slave   hz
);

  localparam int INIT_W = (INIT_FLUSH_CYCLES > 1) ? $clog2(INIT_FLUSH_CYCLES) : 1;
  localparam int TO_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_FLUSH_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(MEM_TIMEOUT);

  hz_state_t          r_state;
  logic [INIT_W-1:0]  r_init_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_mem_timeout;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic               w_load_use;
  logic               w_mem_stall;
  logic               w_run_eval;
  logic               w_inc_stall;
  logic               w_inc_flush;
  pipe_ctl_t          w_ctl;

  hazard_detect u_hazard_detect (
    .i_id_rn         (hz.id_rn),
    .i_id_rm         (hz.id_rm),
    .i_id_uses_rn    (hz.id_uses_rn),
    .i_id_uses_rm    (hz.id_uses_rm),
    .i_ex_rd         (hz.ex_rd),
    .i_ex_reg_wr     (hz.ex_reg_wr),
    .i_ex_mem_to_reg (hz.ex_mem_to_reg),
    .o_load_use      (w_load_use)
  );

  assign w_mem_stall = hz.mem_access & ~hz.dmem_ready;

  // Pipeline controls from state and inputs; memory freeze outranks branch, branch outranks load-use
  always_comb begin
    w_ctl       = ctl_uniform(1'b0, 1'b1);
    w_run_eval  = 1'b0;
    w_inc_stall = 1'b0;
    w_inc_flush = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_ctl = ctl_uniform(1'b0, 1'b1);
      end
      ST_RUN: begin
        if (w_mem_stall) begin
          w_ctl       = ctl_uniform(1'b0, 1'b0);
          w_inc_stall = 1'b1;
        end else begin
          w_run_eval = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // only dmem_ready releases the freeze, mem_access is not looked at here
        if (!hz.dmem_ready) begin
          w_ctl       = ctl_uniform(1'b0, 1'b0);
          w_inc_stall = 1'b1;
        end else begin
          w_run_eval = 1'b1;
        end
      end
      default: begin
        w_ctl = ctl_uniform(1'b0, 1'b1);
      end
    endcase

    if (w_run_eval) begin
      if (hz.ex_branch_taken) begin
        // the would-be consumer of a load is squashed, so no bubble is needed
        w_ctl       = ctl_branch();
        w_inc_flush = 1'b1;
      end else if (w_load_use) begin
        w_ctl       = ctl_load_use();
        w_inc_stall = 1'b1;
      end else begin
        w_ctl = ctl_uniform(1'b1, 1'b0);
      end
    end
  end

  // Sequencer state, init/timeout counters, sticky error flag and saturating perf counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_INIT;
      r_init_cnt    <= '0;
      r_to_cnt      <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == INIT_LAST) begin
            r_state <= ST_RUN;
          end else begin
            r_init_cnt <= r_init_cnt + INIT_W'(1);
          end
        end
        ST_RUN: begin
          if (w_mem_stall) begin
            r_state  <= ST_MEM_WAIT;
            r_to_cnt <= TO_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          // r_to_cnt holds the index of the current waiting cycle
          if (hz.dmem_ready) begin
            r_state <= ST_RUN;
          end else if (r_to_cnt >= TO_LIMIT) begin
            r_mem_timeout <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase

      if (w_inc_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_inc_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign hz.pc_en       = w_ctl.pc_en;
  assign hz.ifid_en     = w_ctl.ifid_en;
  assign hz.idex_en     = w_ctl.idex_en;
  assign hz.exmem_en    = w_ctl.exmem_en;
  assign hz.memwb_en    = w_ctl.memwb_en;
  assign hz.ifid_flush  = w_ctl.ifid_flush;
  assign hz.idex_flush  = w_ctl.idex_flush;
  assign hz.exmem_flush = w_ctl.exmem_flush;
  assign hz.memwb_flush = w_ctl.memwb_flush;
  assign hz.mem_timeout = r_mem_timeout;
  assign hz.stall_cnt   = r_stall_cnt;
  assign hz.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for the stall/flush sequencer: stimulus pushes the
// hand-computed expectation for each cycle, a negedge monitor pops and checks.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int CW = 4;

  // bit order: pc ifid idex exmem memwb enables | ifid idex exmem memwb flushes
  localparam pipe_ctl_t C_INIT = 9'b00000_1111;
  localparam pipe_ctl_t C_RUN  = 9'b11111_0000;
  localparam pipe_ctl_t C_FRZ  = 9'b00000_0000;
  localparam pipe_ctl_t C_BR   = 9'b11111_1100;
  localparam pipe_ctl_t C_LU   = 9'b00111_0100;

  typedef struct {
    int              cyc;
    pipe_ctl_t       ctl;
    logic [CW-1:0]   stall;
    logic [CW-1:0]   flush;
    logic            to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc_now = 0;
  exp_t  exp_q[$];
  string name_q[$];
  pipe_ctl_t act;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz_if();

  pipeline_hazard_ctrl #(
    .INIT_FLUSH_CYCLES (3),
    .MEM_TIMEOUT       (8),
    .CNT_W             (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if)
  );

  assign act = {hz_if.pc_en, hz_if.ifid_en, hz_if.idex_en, hz_if.exmem_en, hz_if.memwb_en,
                hz_if.ifid_flush, hz_if.idex_flush, hz_if.exmem_flush, hz_if.memwb_flush};

  always @(posedge clk) cyc_now <= cyc_now + 1;

  // monitor: check the entry scheduled for this cycle
  always @(negedge clk) begin : mon
    exp_t  e;
    string n;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc_now) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      $display("cyc=%0d %s ctl=%b stall=%0d flush=%0d to=%b", cyc_now, n, act,
               hz_if.stall_cnt, hz_if.flush_cnt, hz_if.mem_timeout);
      total++;
      if (act !== e.ctl) begin
        bad++;
        $display("FAIL %s ctl got=%b want=%b", n, act, e.ctl);
      end
      total++;
      if (hz_if.stall_cnt !== e.stall) begin
        bad++;
        $display("FAIL %s stall_cnt got=%0d want=%0d", n, hz_if.stall_cnt, e.stall);
      end
      total++;
      if (hz_if.flush_cnt !== e.flush) begin
        bad++;
        $display("FAIL %s flush_cnt got=%0d want=%0d", n, hz_if.flush_cnt, e.flush);
      end
      total++;
      if (hz_if.mem_timeout !== e.to) begin
        bad++;
        $display("FAIL %s mem_timeout got=%b want=%b", n, hz_if.mem_timeout, e.to);
      end
    end
  end

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic step(input logic r, input logic [4:0] rn, input logic [4:0] rm,
                      input logic urn, input logic urm, input logic [4:0] rd,
                      input logic wr, input logic m2r, input logic br,
                      input logic ma, input logic rdy,
                      input pipe_ctl_t ec, input int es, input int ef,
                      input logic eto, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst                   = r;
    hz_if.id_rn           = rn;
    hz_if.id_rm           = rm;
    hz_if.id_uses_rn      = urn;
    hz_if.id_uses_rm      = urm;
    hz_if.ex_rd           = rd;
    hz_if.ex_reg_wr       = wr;
    hz_if.ex_mem_to_reg   = m2r;
    hz_if.ex_branch_taken = br;
    hz_if.mem_access      = ma;
    hz_if.dmem_ready      = rdy;
    e.cyc   = cyc_now;
    e.ctl   = ec;
    e.stall = CW'(es);
    e.flush = CW'(ef);
    e.to    = eto;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input pipe_ctl_t ec, input int es, input int ef, input logic eto,
                      input string nm);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ec, es, ef, eto, nm);
  endtask

  initial begin
    hz_if.id_rn = '0; hz_if.id_rm = '0; hz_if.id_uses_rn = 1'b0; hz_if.id_uses_rm = 1'b0;
    hz_if.ex_rd = '0; hz_if.ex_reg_wr = 1'b0; hz_if.ex_mem_to_reg = 1'b0;
    hz_if.ex_branch_taken = 1'b0; hz_if.mem_access = 1'b0; hz_if.dmem_ready = 1'b0;

    // reset hold, then exactly three flush cycles after release
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_INIT, 0, 0, 1'b0, "reset_hold0");
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_INIT, 0, 0, 1'b0, "reset_hold1");
    idle(C_INIT, 0, 0, 1'b0, "init1");
    idle(C_INIT, 0, 0, 1'b0, "init2");
    idle(C_INIT, 0, 0, 1'b0, "init3");
    idle(C_RUN, 0, 0, 1'b0, "run_first");

    // load-use on Rm, XZR exemption, Rn path, use bit and non-load cases
    step(1'b1, 0, 5, 0, 1, 5, 1, 1, 0, 0, 0, C_LU, 0, 0, 1'b0, "lu_rm");
    idle(C_RUN, 1, 0, 1'b0, "after_lu");
    step(1'b1, 0, 31, 0, 1, 31, 1, 1, 0, 0, 0, C_RUN, 1, 0, 1'b0, "xzr_no_hazard");
    step(1'b1, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0, C_LU, 1, 0, 1'b0, "lu_rn");
    step(1'b1, 7, 0, 0, 0, 7, 1, 1, 0, 0, 0, C_RUN, 2, 0, 1'b0, "no_use_bit");
    step(1'b1, 7, 0, 1, 0, 7, 1, 0, 0, 0, 0, C_RUN, 2, 0, 1'b0, "not_a_load");

    // taken branch wins over a live load-use condition
    step(1'b1, 0, 5, 0, 1, 5, 1, 1, 1, 0, 0, C_BR, 2, 0, 1'b0, "branch_over_lu");
    idle(C_RUN, 2, 1, 1'b0, "after_branch");

    // memory wait with branch held: frozen 4 cycles, flush only on release
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 2, 1, 1'b0, "mem_stall_run");
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 3, 1, 1'b0, "mem_wait1");
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_FRZ, 4, 1, 1'b0, "mem_wait_access_dropped");
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ, 5, 1, 1'b0, "mem_wait3");
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_BR, 6, 1, 1'b0, "mem_release_branch");
    idle(C_RUN, 6, 2, 1'b0, "after_release");
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 6, 2, 1'b0, "mem_ready_same_cycle");

    // timeout: flag visible after the 8th waiting cycle; stall_cnt saturates
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 6, 2, 1'b0, "to_stall");
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, mn(6 + k, 15), 2, (k >= 9),
           $sformatf("to_wait%0d", k));
    end

    // asynchronous reset clears everything before any clock edge
    step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_INIT, 0, 0, 1'b0, "reset_pulse");
    idle(C_INIT, 0, 0, 1'b0, "reinit1");
    idle(C_INIT, 0, 0, 1'b0, "reinit2");
    idle(C_INIT, 0, 0, 1'b0, "reinit3");
    idle(C_RUN, 0, 0, 1'b0, "rerun");

    // 20 back-to-back load-use stalls saturate the 4-bit counter at 15
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 0, 5, 0, 1, 5, 1, 1, 0, 0, 0, C_LU, mn(i, 15), 0, 1'b0,
           $sformatf("sat_lu%0d", i));
    end
    idle(C_RUN, 15, 0, 1'b0, "sat_hold");

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
